// File: rtl/parallel_to_serial.sv
// LSB-first parallel-to-serial shifter with a one-word holding buffer so frames stream without gap bits.
// Optional PTS_PARITY_EN appends an even-parity bit to every frame.
module parallel_to_serial #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] data_in,
   input  logic         load,
   output logic         ready,
   output logic         data_out,
   output logic         data_valid,
   output logic         busy,
   output logic         empty_tick
);

`ifdef PTS_PARITY_EN
   localparam int FRAME_LEN = N + 1;
`else
   localparam int FRAME_LEN = N;
`endif
   localparam int CW = $clog2(N + 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t               state;
   logic [FRAME_LEN-2:0] shreg;   // bits still to send after the one on data_out
   logic [CW-1:0]        bit_cnt;
   logic [N-1:0]         buf_q;
   logic                 buf_valid;

   logic [N-1:0]         ld_word;
   logic [FRAME_LEN-1:0] ld_frame;
   logic                 last_bit;

   // A buffered word always wins over data_in; in IDLE the buffer is empty.
   assign ld_word  = buf_valid ? buf_q : data_in;
`ifdef PTS_PARITY_EN
   assign ld_frame = {^ld_word, ld_word};
`else
   assign ld_frame = ld_word;
`endif
   assign last_bit = (bit_cnt == CW'(FRAME_LEN - 1));
   assign ready    = ~buf_valid;
   assign busy     = data_valid;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         shreg      <= '0;
         bit_cnt    <= '0;
         buf_q      <= '0;
         buf_valid  <= 1'b0;
         data_out   <= 1'b0;
         data_valid <= 1'b0;
         empty_tick <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (load) begin
                  state      <= SHIFT;
                  data_out   <= ld_frame[0];
                  shreg      <= ld_frame[FRAME_LEN-1:1];
                  bit_cnt    <= '0;
                  data_valid <= 1'b1;
                  empty_tick <= 1'b0;
               end else begin
                  data_out   <= 1'b0;
                  data_valid <= 1'b0;
                  empty_tick <= 1'b0;
               end
            end
            SHIFT: begin
               if (!last_bit) begin
                  data_out   <= shreg[0];
                  shreg      <= shreg >> 1;
                  bit_cnt    <= bit_cnt + 1'b1;
                  empty_tick <= (bit_cnt == CW'(FRAME_LEN - 2));
                  if (load && !buf_valid) begin
                     buf_q     <= data_in;
                     buf_valid <= 1'b1;
                  end
               end else if (buf_valid || load) begin
                  // Next frame starts right behind the last bit: no gap.
                  data_out   <= ld_frame[0];
                  shreg      <= ld_frame[FRAME_LEN-1:1];
                  bit_cnt    <= '0;
                  buf_valid  <= 1'b0;
                  empty_tick <= 1'b0;
               end else begin
                  state      <= IDLE;
                  data_out   <= 1'b0;
                  data_valid <= 1'b0;
                  empty_tick <= 1'b0;
                  shreg      <= '0;
                  bit_cnt    <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_parallel_to_serial.sv
// Scoreboard bench for parallel_to_serial: driver pushes hand-written expected frames, a negedge monitor pops and compares.
module tb_parallel_to_serial;
   localparam int N = 8;
`ifdef PTS_PARITY_EN
   localparam int FL = N + 1;
`else
   localparam int FL = N;
`endif

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [N-1:0] data_in = '0;
   logic         load = 1'b0;
   logic         ready, data_out, data_valid, busy, empty_tick;

   int checks = 0;
   int errors = 0;

   typedef struct packed {logic b; logic t;} exp_t;
   exp_t q[$];
   logic prev_v = 1'b0;

   parallel_to_serial #(.N(N)) dut (
      .clk(clk), .reset(reset), .data_in(data_in), .load(load), .ready(ready),
      .data_out(data_out), .data_valid(data_valid), .busy(busy), .empty_tick(empty_tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Frame as seen on the line: bit i is the i-th serial bit; p is the hand-computed parity.
   function automatic logic [FL-1:0] fr(input logic [N-1:0] w, input logic p);
      return FL'({p, w});
   endfunction

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send(input logic [N-1:0] w, input logic [FL-1:0] exp);
      exp_t e;
      bit ok = 0;
      data_in = w;
      load = 1'b1;
      for (int k = 0; k < 100; k++) begin
         if (ready) begin
            for (int i = 0; i < FL; i++) begin
               e.b = exp[i];
               e.t = (i == FL - 1);
               q.push_back(e);
            end
            ok = 1;
            @(negedge clk);
            break;
         end
         @(negedge clk);
      end
      load = 1'b0;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL accept_timeout: word %h never accepted", w);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         prev_v = 1'b0;
      end else begin
         chk("busy_eq_valid", busy, data_valid);
         if (data_valid) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_bit: data_out=%b with nothing expected at %0t", data_out, $time);
            end else begin
               e = q.pop_front();
               chk("serial_bit", data_out, e.b);
               chk("empty_tick", empty_tick, e.t);
            end
         end else begin
            chk("idle_data_out", data_out, 1'b0);
            chk("idle_tick", empty_tick, 1'b0);
            if (prev_v) begin
               checks++;
               if (q.size() != 0) begin
                  errors++;
                  $display("FAIL gap: valid dropped with %0d bits pending at %0t", q.size(), $time);
               end
            end
         end
         prev_v = data_valid;
      end
   end

   initial begin
      // T1 reset
      @(posedge clk); @(posedge clk); @(negedge clk);
      chk("rst_data_out", data_out, 1'b0);
      chk("rst_valid", data_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_tick", empty_tick, 1'b0);
      chk("rst_ready", ready, 1'b1);
      reset = 1'b0;
      @(negedge clk);

      // T2 single word 0x69 -> 1,0,0,1,0,1,1,0
      send(8'h69, fr(8'b0110_1001, 1'b0));
      repeat (12) @(negedge clk);

      // T3/T4 back-to-back with a blocked load while the buffer is full
      send(8'h69, fr(8'b0110_1001, 1'b0));            // N1: bit0 on line
      send(8'h0A, fr(8'b0000_1010, 1'b0));            // N2: buffer full
      chk("ready_low_buf_full", ready, 1'b0);
      data_in = 8'hFF;
      load = 1'b1;
      @(negedge clk);                                  // N3
      load = 1'b0;
      data_in = 8'h00;
      repeat (5) @(negedge clk);                       // N8: 8th bit of first word
      chk("ready_low_last_bit", ready, 1'b0);
      @(negedge clk);                                  // N9: buffer moved to shifter
      chk("ready_high_after_swap", ready, 1'b1);
      repeat (12) @(negedge clk);

      // Word offered exactly on the last bit goes straight to the shifter
      send(8'hA5, fr(8'b1010_0101, 1'b0));
      repeat (7) @(negedge clk);
      send(8'h3C, fr(8'b0011_1100, 1'b0));
      repeat (12) @(negedge clk);

      // Continuous producer: third word waits for ready
      send(8'h81, fr(8'b1000_0001, 1'b0));
      send(8'hFE, fr(8'b1111_1110, 1'b1));
      send(8'h07, fr(8'b0000_0111, 1'b1));
      repeat (30) @(negedge clk);

      // T5 reset mid-frame with 0x0F buffered
      send(8'hFF, fr(8'b1111_1111, 1'b0));
      send(8'h0F, fr(8'b0000_1111, 1'b0));
      @(negedge clk); @(negedge clk);                  // 4th bit on line
      reset = 1'b1;
      q.delete();
      @(negedge clk);
      chk("midrst_data_out", data_out, 1'b0);
      chk("midrst_valid", data_valid, 1'b0);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_ready", ready, 1'b1);
      chk("midrst_tick", empty_tick, 1'b0);
      reset = 1'b0;
      repeat (12) @(negedge clk);

      // T6 parity frames (parity bit appears only when enabled)
      send(8'h07, fr(8'b0000_0111, 1'b1));
      repeat (12) @(negedge clk);
      send(8'h69, fr(8'b0110_1001, 1'b0));
      repeat (12) @(negedge clk);

      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected bits never appeared", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
